// File: rtl/alu_cmd_tx.sv
// alu_cmd_tx: buffers a packet of 32-bit operand words, then emits it as a framed byte stream.
// Optional macro ALU_TX_CRLF_EN appends a 0x0D 0x0A trailer and counts it in LEN.

module alu_cmd_tx #(
  parameter int MAX_WORDS = 8,
  parameter int AXI_WIDTH = 8
) (
  input  logic        s_axis_aclk_i,
  input  logic        s_axis_arst_ni,
  input  logic [31:0] s_axis_tdata_i,
  input  logic [7:0]  s_axis_tuser_i,
  input  logic        s_axis_tvalid_i,
  input  logic        s_axis_tlast_i,
  output logic        s_axis_tready_o,
  output logic [7:0]  m_axis_tdata_o,
  output logic        m_axis_tvalid_o,
  output logic        m_axis_tlast_o,
  input  logic        m_axis_tready_i,
  output logic        overflow_o,
  output logic        busy_o
);

  // Valid/ready on both sides: a beat transfers on a rising edge where tvalid and tready are
  // both high; the source keeps tdata/tlast stable from raising tvalid until that transfer.

  if (AXI_WIDTH != 8) begin : g_width_check
    $error("alu_cmd_tx: AXI_WIDTH must be 8");
  end

  localparam int         AW    = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

`ifdef ALU_TX_CRLF_EN
  localparam logic [15:0] TRAIL_BYTES = 16'd2;
  typedef enum logic [1:0] {COLLECT, HDR, DATA, TRAIL} state_e;
`else
  localparam logic [15:0] TRAIL_BYTES = 16'd0;
  typedef enum logic [1:0] {COLLECT, HDR, DATA} state_e;
`endif

  state_e          state, state_n;
  logic [7:0]      count, count_n;
  logic [7:0]      opcode, opcode_n;
  logic            discard, discard_n;
  logic [1:0]      lane, lane_n;
  logic [AW-1:0]   widx, widx_n;
  logic [31:0]     buffer [MAX_WORDS];
  logic [31:0]     rd_word;
  logic [15:0]     len_n;
  logic            accept, m_hs, last_word;
  logic [7:0]      tdata_n;
  logic            tvalid_n, tlast_n, s_ready_n, ovf_n, busy_n;

  assign accept    = (state == COLLECT) && s_axis_tready_o && s_axis_tvalid_i;
  assign m_hs      = m_axis_tvalid_o && m_axis_tready_i;
  assign last_word = (8'(widx) == (count - 8'd1));

  always_ff @(posedge s_axis_aclk_i) begin
    if (!s_axis_arst_ni) state <= COLLECT;
    else                 state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      COLLECT: if (accept && s_axis_tlast_i) state_n = HDR;
      HDR:     if (m_hs && lane == 2'd3) state_n = DATA;
`ifdef ALU_TX_CRLF_EN
      DATA:    if (m_hs && lane == 2'd3 && last_word) state_n = TRAIL;
      TRAIL:   if (m_hs && lane == 2'd1) state_n = COLLECT;
`else
      DATA:    if (m_hs && lane == 2'd3 && last_word) state_n = COLLECT;
`endif
      default: state_n = COLLECT;
    endcase
  end

  // Next values of the datapath registers; the outputs below are decoded from these.
  always_comb begin
    count_n   = count;
    opcode_n  = opcode;
    discard_n = discard;
    lane_n    = lane;
    widx_n    = widx;
    if (accept) begin
      if (count == 8'd0) opcode_n = s_axis_tuser_i;
      if (count < MAX_N) count_n = count + 8'd1;
      else               discard_n = 1'b1;
    end
    if (m_hs && state != COLLECT) begin
      lane_n = lane + 2'd1;
      if (state == DATA && lane == 2'd3) widx_n = widx + AW'(1);
    end
    if (state_n != state) lane_n = 2'd0;
    if (state_n != DATA)  widx_n = '0;
    if (state != COLLECT && state_n == COLLECT) begin
      count_n   = 8'd0;
      discard_n = 1'b0;
    end
  end

  always_comb begin
    len_n     = 16'd4 + {6'd0, count_n, 2'b00} + TRAIL_BYTES;
    rd_word   = buffer[widx_n];
    tvalid_n  = (state_n != COLLECT);
    s_ready_n = (state_n == COLLECT);
    busy_n    = (state_n != COLLECT);
    ovf_n     = accept && s_axis_tlast_i && discard_n;
    tdata_n   = 8'd0;
    tlast_n   = 1'b0;
    case (state_n)
      HDR: begin
        case (lane_n)
          2'd0:    tdata_n = opcode_n;
          2'd1:    tdata_n = count_n;
          2'd2:    tdata_n = len_n[7:0];
          default: tdata_n = len_n[15:8];
        endcase
      end
      DATA: begin
        case (lane_n)
          2'd0:    tdata_n = rd_word[7:0];
          2'd1:    tdata_n = rd_word[15:8];
          2'd2:    tdata_n = rd_word[23:16];
          default: tdata_n = rd_word[31:24];
        endcase
`ifndef ALU_TX_CRLF_EN
        tlast_n = (lane_n == 2'd3) && (8'(widx_n) == (count_n - 8'd1));
`endif
      end
`ifdef ALU_TX_CRLF_EN
      TRAIL: begin
        tdata_n = lane_n[0] ? 8'h0A : 8'h0D;
        tlast_n = lane_n[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge s_axis_aclk_i) begin
    if (!s_axis_arst_ni) begin
      count           <= 8'd0;
      opcode          <= 8'd0;
      discard         <= 1'b0;
      lane            <= 2'd0;
      widx            <= '0;
      s_axis_tready_o <= 1'b0;
      m_axis_tdata_o  <= 8'd0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
      overflow_o      <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      count           <= count_n;
      opcode          <= opcode_n;
      discard         <= discard_n;
      lane            <= lane_n;
      widx            <= widx_n;
      s_axis_tready_o <= s_ready_n;
      m_axis_tdata_o  <= tdata_n;
      m_axis_tvalid_o <= tvalid_n;
      m_axis_tlast_o  <= tlast_n;
      overflow_o      <= ovf_n;
      busy_o          <= busy_n;
    end
  end

  // Words past MAX_WORDS are accepted but never stored.
  always_ff @(posedge s_axis_aclk_i) begin
    if (accept && count < MAX_N) buffer[count[AW-1:0]] <= s_axis_tdata_i;
  end

endmodule

// File: tb/tb_alu_cmd_tx.sv
// Bench for alu_cmd_tx: random packets and backpressure against a byte-queue packet model.
// Build with +define+ALU_TX_CRLF_EN to exercise the trailer variant.

module tb_alu_cmd_tx;
  localparam int MAX_WORDS = 8;
`ifdef ALU_TX_CRLF_EN
  localparam int TRAIL = 2;
`else
  localparam int TRAIL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [7:0]  s_tuser = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tlast, m_tready = 1'b1;
  logic        overflow, busy;

  alu_cmd_tx #(.MAX_WORDS(MAX_WORDS), .AXI_WIDTH(8)) dut (
    .s_axis_aclk_i(clk), .s_axis_arst_ni(rst_n),
    .s_axis_tdata_i(s_tdata), .s_axis_tuser_i(s_tuser), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tlast_o(m_tlast),
    .m_axis_tready_i(m_tready), .overflow_o(overflow), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int hs_cnt = 0, ovf_cnt = 0, rdy_mode = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  bb_q[$];
  logic [7:0]  lit_q[$];
  logic [31:0] bw_q[$];
  logic [31:0] cur_words[$];
  logic [31:0] tx_words[$];
  logic [7:0]  cur_op;
  bit          cur_started = 0, pend_ovf = 0, prev_rst = 0, prev_stall = 0;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic [7:0]  lit1_a [8]  = '{8'hA5, 8'h01, 8'h08, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0]  lit3_a [16] = '{8'h03, 8'h03, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                               8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet model: header, first MAX_WORDS words little-endian, optional CR LF.
  function automatic void build_pkt(input logic [7:0] op);
    int n;
    logic [15:0] len;
    logic [31:0] w;
    n = (bw_q.size() > MAX_WORDS) ? MAX_WORDS : bw_q.size();
    len = 16'(4 + 4 * n + TRAIL);
    bb_q.delete();
    bb_q.push_back(op);
    bb_q.push_back(8'(n));
    bb_q.push_back(len[7:0]);
    bb_q.push_back(len[15:8]);
    for (int i = 0; i < n; i++) begin
      w = bw_q[i];
      for (int k = 0; k < 4; k++) bb_q.push_back(w[8*k +: 8]);
    end
    if (TRAIL == 2) begin
      bb_q.push_back(8'h0D);
      bb_q.push_back(8'h0A);
    end
  endfunction

  task automatic set_lit(input int which);
    lit_q.delete();
    if (which == 1) foreach (lit1_a[i]) lit_q.push_back(lit1_a[i]);
    else if (which == 3) foreach (lit3_a[i]) lit_q.push_back(lit3_a[i]);
    else begin
      lit_q.push_back(8'h5A); lit_q.push_back(8'h08); lit_q.push_back(8'h24); lit_q.push_back(8'h00);
      for (int i = 0; i < 8; i++) begin
        lit_q.push_back(8'(i)); lit_q.push_back(8'h00); lit_q.push_back(8'h00); lit_q.push_back(8'h00);
      end
    end
`ifdef ALU_TX_CRLF_EN
    lit_q[2] = lit_q[2] + 8'd2;
    lit_q.push_back(8'h0D);
    lit_q.push_back(8'h0A);
`endif
  endtask

  task automatic cmp_lit(input string name, input bit use_got);
    logic [7:0] a[$];
    int bad;
    if (use_got) a = got_q; else a = bb_q;
    bad = -1;
    if (a.size() != lit_q.size()) bad = a.size();
    else foreach (a[i]) if (bad < 0 && a[i] !== lit_q[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: got %0d bytes (first bad index %0d) expected %0d bytes", name, a.size(), bad, lit_q.size());
    end
  endtask

  // Compare process: every negedge, outputs against the model; then update the model.
  always @(negedge clk) begin
    bit in_flight;
    logic [7:0] e;
    if (!prev_rst) begin
      check("reset_outputs", 32'({m_tvalid, m_tlast, m_tdata, overflow, busy, s_tready}), 32'd0);
    end else begin
      in_flight = (exp_q.size() != 0);
      check("s_tready", 32'(s_tready), 32'(!in_flight));
      check("m_tvalid", 32'(m_tvalid), 32'(in_flight));
      check("busy", 32'(busy), 32'(in_flight));
      check("overflow", 32'(overflow), 32'(pend_ovf));
      if (overflow) ovf_cnt++;
      if (prev_stall) check("stall_hold", 32'({m_tdata, m_tlast}), 32'({prev_data, prev_last}));
      if (rst_n && m_tvalid && m_tready && in_flight) begin
        e = exp_q.pop_front();
        check("tdata", 32'(m_tdata), 32'(e));
        check("tlast", 32'(m_tlast), 32'(exp_q.size() == 0));
        got_q.push_back(m_tdata);
        hs_cnt++;
      end
    end
    pend_ovf   = 0;
    prev_stall = rst_n && m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (!rst_n) begin
      exp_q.delete();
      cur_words.delete();
      cur_started = 0;
    end else if (s_tvalid && s_tready) begin
      if (!cur_started) begin
        cur_op = s_tuser;
        cur_started = 1;
      end
      cur_words.push_back(s_tdata);
      if (s_tlast) begin
        bw_q = cur_words;
        build_pkt(cur_op);
        exp_q = bb_q;
        pend_ovf = (cur_words.size() > MAX_WORDS);
        cur_words.delete();
        cur_started = 0;
      end
    end
    prev_rst = rst_n;
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_word(input logic [31:0] w, input logic [7:0] op, input bit last);
    int t;
    t = 0;
    s_tdata = w; s_tuser = op; s_tlast = last; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got tready 0 expected 1 within 3000 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_pkt(input logic [7:0] op, input int gap_max);
    int k;
    for (int i = 0; i < tx_words.size(); i++) begin
      send_word(tx_words[i], (i == 0) ? op : 8'($urandom), i == tx_words.size() - 1);
      if (gap_max > 0 && i != tx_words.size() - 1) begin
        k = $urandom_range(0, gap_max);
        if (k > 0) begin
          s_tvalid = 1'b0;
          repeat (k) @(posedge clk);
          #1;
        end
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || cur_started) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int base, t;
    // Pin the model to hand-computed packets.
    bw_q.delete(); bw_q.push_back(32'h11223344);
    build_pkt(8'hA5); set_lit(1); cmp_lit("model_single", 0);
    bw_q.delete(); bw_q.push_back(32'h1); bw_q.push_back(32'h2); bw_q.push_back(32'hDEADBEEF);
    build_pkt(8'h03); set_lit(3); cmp_lit("model_three", 0);
    bw_q.delete(); for (int i = 0; i < 10; i++) bw_q.push_back(32'(i));
    build_pkt(8'h5A); set_lit(8); cmp_lit("model_overflow", 0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    got_q.delete();
    tx_words.delete(); tx_words.push_back(32'h11223344);
    send_pkt(8'hA5, 0); wait_idle();
    set_lit(1); cmp_lit("dut_single", 1);

    got_q.delete();
    tx_words.delete(); tx_words.push_back(32'h1); tx_words.push_back(32'h2); tx_words.push_back(32'hDEADBEEF);
    send_pkt(8'h03, 0); wait_idle();
    set_lit(3); cmp_lit("dut_three", 1);

    got_q.delete(); rdy_mode = 1;
    send_pkt(8'h03, 0); wait_idle();
    cmp_lit("dut_backpressure", 1);

    got_q.delete(); rdy_mode = 0; ovf_cnt = 0;
    tx_words.delete(); for (int i = 0; i < 10; i++) tx_words.push_back(32'(i));
    send_pkt(8'h5A, 0); wait_idle();
    set_lit(8); cmp_lit("dut_overflow", 1);
    check("overflow_pulses", 32'(ovf_cnt), 32'd1);

    // Reset in the middle of DATA, just after byte 5 transfers.
    tx_words.delete(); tx_words.push_back(32'h1); tx_words.push_back(32'h2); tx_words.push_back(32'hDEADBEEF);
    base = hs_cnt; t = 0;
    send_pkt(8'h03, 0);
    while (hs_cnt < base + 6 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reset_point_reached", 32'(hs_cnt - base >= 6), 32'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    tx_words.delete(); tx_words.push_back(32'h11223344);
    send_pkt(8'hA5, 0); wait_idle();
    set_lit(1); cmp_lit("dut_after_reset", 1);

    // Back-to-back single-word packets with tvalid held high.
    got_q.delete();
    send_word(32'hCAFEF00D, 8'h11, 1'b1);
    send_word(32'h0BADBEEF, 8'h22, 1'b1);
    s_tvalid = 1'b0;
    wait_idle();
    check("b2b_bytes", 32'(got_q.size()), 32'(2 * (8 + TRAIL)));
    if (got_q.size() == 2 * (8 + TRAIL)) begin
      check("b2b_op0", 32'(got_q[0]), 32'h11);
      check("b2b_op1", 32'(got_q[8 + TRAIL]), 32'h22);
      check("b2b_word1", 32'(got_q[8 + TRAIL + 4]), 32'hEF);
    end

    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      tx_words.delete();
      for (int i = 0; i < int'($urandom_range(1, MAX_WORDS + 3)); i++) tx_words.push_back($urandom);
      send_pkt(8'($urandom), 2);
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got still running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
